// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Oversampling UART receiver with optional parity, stop-bit check,
//            break detection and a one-word holding register with overrun.
// Revision : 1.0
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS      = 8,
    parameter int OVERSAMPLE     = 16,
    parameter int CLK_PER_SAMPLE = 163,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] datos,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_DIV_W  = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_PER_SAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_FULL_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_PAR   = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;
    localparam logic [2:0] c_ST_BREAK = 3'd5;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]           state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [c_TICK_W-1:0]  tick_q, tick_d;
    logic [c_BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] datos_q, datos_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic w_tick;
    logic w_fall;
    logic w_sample;
    logic w_done;
    logic w_done_ferr;
    logic w_par_x;
    logic w_perr;

    assign w_tick  = (div_q == c_DIV_LAST);
    assign w_fall  = rx_prev_q & ~rx_sync_q;
    assign w_par_x = ^{shift_q, par_bit_q};
    assign w_perr  = (PARITY == 1) ? w_par_x : ((PARITY == 2) ? ~w_par_x : 1'b0);

    always_comb begin
        state_d     = state_q;
        div_d       = w_tick ? '0 : div_q + 1'b1;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        stop_err_d  = stop_err_q;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        w_done_ferr = 1'b0;

        // Half a bit in START lands on the start-bit centre; full bits after that.
        if (state_q != c_ST_IDLE && state_q != c_ST_BREAK && w_tick) begin
            if (tick_q == ((state_q == c_ST_START) ? c_HALF_LAST : c_FULL_LAST)) begin
                w_sample = 1'b1;
                tick_d   = '0;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        case (state_q)
            c_ST_IDLE: begin
                if (w_fall) begin
                    state_d    = c_ST_START;
                    div_d      = '0;
                    tick_d     = '0;
                    bit_d      = '0;
                    stop_err_d = 1'b0;
                end
            end
            c_ST_START: begin
                if (w_sample) begin
                    state_d = rx_sync_q ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_sample) begin
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == c_DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? c_ST_PAR : c_ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            c_ST_PAR: begin
                if (w_sample) begin
                    par_bit_d = rx_sync_q;
                    state_d   = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_sample) begin
                    if (bit_q == c_STOP_LAST) begin
                        w_done      = 1'b1;
                        w_done_ferr = stop_err_q | ~rx_sync_q;
                        bit_d       = '0;
                        state_d     = rx_sync_q ? c_ST_IDLE : c_ST_BREAK;
                    end else begin
                        stop_err_d = stop_err_q | ~rx_sync_q;
                        bit_d      = bit_q + 1'b1;
                    end
                end
            end
            c_ST_BREAK: begin
                if (rx_sync_q) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // A completing frame may load in the same cycle the held word is taken.
    always_comb begin
        datos_d = datos_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        valid_d = valid_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (w_done) begin
            if (!valid_q || ready) begin
                datos_d = shift_q;
                perr_d  = w_perr;
                ferr_d  = w_done_ferr;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= c_ST_IDLE;
            div_q      <= '0;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            datos_q    <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop_err_q <= stop_err_d;
            datos_q    <= datos_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign datos      = datos_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Self-checking bench: no-parity and even-parity receivers at
//            64 clk per bit, table vectors, corner sequences, random frames.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx0, rx1;
    logic       ready0, ready1;
    logic [7:0] datos0, datos1;
    logic       valid0, valid1, pe0, pe1, fe0, fe1, ovr0, ovr1, busy0, busy1;

    int n_checks = 0;
    int n_err    = 0;
    int vhigh0   = 0;

    logic [9:0] got0[$];
    logic [9:0] got1[$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_PER_SAMPLE(4),
                    .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .datos(datos0), .valid(valid0),
        .ready(ready0), .parity_err(pe0), .frame_err(fe0), .overrun(ovr0),
        .busy(busy0));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .CLK_PER_SAMPLE(4),
                    .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .datos(datos1), .valid(valid1),
        .ready(ready1), .parity_err(pe1), .frame_err(fe1), .overrun(ovr1),
        .busy(busy1));

    always @(negedge clk) begin
        if (valid0 && ready0) got0.push_back({datos0, pe0, fe0});
        if (valid1 && ready1) got1.push_back({datos1, pe1, fe1});
        if (valid0) vhigh0 <= vhigh0 + 1;
    end

    // Reference: what a frame should deliver, from the line-level rules.
    function automatic logic [9:0] model(input logic [7:0] d, input logic pbit,
                                         input int mode, input logic stop_low);
        int   ones;
        logic pe;
        ones = $countones({d, pbit});
        pe   = (mode == 1) ? (ones % 2 == 1) : ((mode == 2) ? (ones % 2 == 0) : 1'b0);
        return {d, pe, stop_low};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input bit sel, input string name, input logic [9:0] exp);
        logic [9:0] r;
        bit         empty;
        empty = sel ? (got1.size() == 0) : (got0.size() == 0);
        if (empty) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: no word delivered, expected data %0h", name, exp[9:2]);
        end else begin
            if (sel) r = got1.pop_front();
            else     r = got0.pop_front();
            check({name, "_data"}, {24'd0, r[9:2]}, {24'd0, exp[9:2]});
            check({name, "_perr"}, {31'd0, r[1]}, {31'd0, exp[1]});
            check({name, "_ferr"}, {31'd0, r[0]}, {31'd0, exp[0]});
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        #1;
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    task automatic hold_bit();
        repeat (64) @(posedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit use_par,
                        input logic pbit, input logic stop_lvl);
        drive(sel, 1'b0);
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            hold_bit();
        end
        if (use_par) begin
            drive(sel, pbit);
            hold_bit();
        end
        drive(sel, stop_lvl);
        hold_bit();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop_low;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t       tbl[6];
    logic [9:0] exp_q[$];

    initial begin
        logic [7:0] d;
        logic       sl;
        int         n0;
        int         vbase;

        // Even-parity vectors for the PARITY=1 receiver.
        tbl[0] = '{8'h03, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
        tbl[1] = '{8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};

        rst_n  = 1'b0;
        rx0    = 1'b1;
        rx1    = 1'b1;
        ready0 = 1'b1;
        ready1 = 1'b1;
        wait_clks(3);
        check("rst_datos", {24'd0, datos0}, 32'd0);
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_perr",  {31'd0, pe0},    32'd0);
        check("rst_ferr",  {31'd0, fe0},    32'd0);
        check("rst_ovr",   {31'd0, ovr0},   32'd0);
        check("rst_busy",  {31'd0, busy0},  32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        for (int i = 0; i < 6; i++) begin
            send(1'b1, tbl[i].data, 1'b1, tbl[i].pbit, ~tbl[i].stop_low);
            drive(1'b1, 1'b1);
            wait_clks(20);
            pop_check(1'b1, $sformatf("par_vec%0d", i),
                      {tbl[i].exp_data, tbl[i].exp_pe, tbl[i].exp_fe});
            check($sformatf("par_vec%0d_busy", i), {31'd0, busy1}, 32'd0);
        end

        vbase = vhigh0;
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clks(10);
        pop_check(1'b0, "frame_a5", {8'hA5, 2'b00});
        check("a5_valid_cycles", vhigh0 - vbase, 32'd1);
        check("a5_busy_after", {31'd0, busy0}, 32'd0);

        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
        wait_clks(136);
        check("break_busy", {31'd0, busy0}, 32'd1);
        pop_check(1'b0, "frame_5a_ferr", {8'h5A, 2'b01});
        drive(1'b0, 1'b1);
        wait_clks(10);
        check("break_exit_busy", {31'd0, busy0}, 32'd0);
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_clks(10);
        pop_check(1'b0, "frame_11", {8'h11, 2'b00});

        n0 = got0.size();
        drive(1'b0, 1'b0);
        repeat (20) @(posedge clk);
        drive(1'b0, 1'b1);
        wait_clks(80);
        check("glitch_no_word", got0.size(), n0);
        check("glitch_valid", {31'd0, valid0}, 32'd0);
        check("glitch_busy", {31'd0, busy0}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            sl = ($urandom_range(0, 3) == 0);
            send(1'b0, d, 1'b0, 1'b0, ~sl);
            exp_q.push_back(model(d, 1'b0, 0, sl));
            if (sl) begin
                drive(1'b0, 1'b1);
                repeat ($urandom_range(5, 20)) @(posedge clk);
            end else begin
                repeat ($urandom_range(0, 8)) @(posedge clk);
            end
        end
        wait_clks(20);
        for (int i = 0; i < 20; i++) begin
            pop_check(1'b0, $sformatf("rand%0d", i), exp_q.pop_front());
        end

        ready0 = 1'b0;
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
        wait_clks(10);
        check("ovr_valid", {31'd0, valid0}, 32'd1);
        check("ovr_datos", {24'd0, datos0}, 32'h12);
        check("ovr_flag", {31'd0, ovr0}, 32'd1);
        @(posedge clk);
        #1 ready0 = 1'b1;
        @(posedge clk);
        #1 ready0 = 1'b0;
        wait_clks(2);
        check("ovr_clr_valid", {31'd0, valid0}, 32'd0);
        check("ovr_clr_flag", {31'd0, ovr0}, 32'd0);
        pop_check(1'b0, "ovr_taken", {8'h12, 2'b00});
        ready0 = 1'b1;

        drive(1'b0, 1'b0);
        hold_bit();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1);
            hold_bit();
        end
        drive(1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        check("pre_rst_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_datos", {24'd0, datos0}, 32'd0);
        check("mid_rst_valid", {31'd0, valid0}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy0},  32'd0);
        check("mid_rst_ovr",   {31'd0, ovr0},   32'd0);
        drive(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clks(20);
        check("post_rst_busy", {31'd0, busy0}, 32'd0);
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_clks(10);
        pop_check(1'b0, "frame_c3", {8'hC3, 2'b00});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (legal 8 or 16).
REQ-003 SHALL have parameter CLK_PER_SAMPLE, default 163, clk cycles per sample tick (legal >=2).
REQ-004 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-006 SHALL have port clk, input, 1, single system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port datos, output, DATA_BITS, received word, LSB received first.
REQ-010 SHALL have port valid, output, 1, datos/error flags hold a complete frame.
REQ-011 SHALL have port ready, input, 1, consumer accepts word when valid&&ready.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch for word presented.
REQ-013 SHALL have port frame_err, output, 1, a stop bit sampled low for word presented.
REQ-014 SHALL have port overrun, output, 1, sticky: a frame was dropped because the holding register was full.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser; all decisions use the synchronised value (2-cycle input latency).
REQ-017 SHALL derive a sample tick every CLK_PER_SAMPLE clk cycles from a free-running counter, reset to 0 on entering START.
REQ-018 SHALL implement states IDLE, START, DATA, PAR, STOP, BREAK.
REQ-019 IDLE -> START on synchronised rx high-to-low transition.
REQ-020 START: after OVERSAMPLE/2 ticks, sample rx; low -> DATA, high -> IDLE (false start, nothing reported).
REQ-021 DATA: sample every OVERSAMPLE ticks (bit centre), shift LSB-first, DATA_BITS samples, then PAR if PARITY!=0 else STOP.
REQ-022 PAR: one centre sample; even mode error if XOR(data,parity bit)=1, odd mode error if =0.
REQ-023 STOP: STOP_BITS centre samples; any low sample sets frame error for this frame.
REQ-024 Frame completes at the last stop-bit centre sample; next state IDLE if rx high, BREAK if rx low.
REQ-025 BREAK: remain until synchronised rx high, then IDLE; no new frame accepted while in BREAK.
REQ-026 On completion with valid=0 (or valid&&ready in the same cycle): load datos, parity_err, frame_err; set valid next cycle.
REQ-027 On completion with valid=1 and ready=0: discard new frame, keep held word and flags unchanged, set overrun.
REQ-028 valid SHALL clear the cycle after valid&&ready unless REQ-026 reloads in that same cycle (valid stays 1).
REQ-029 overrun SHALL clear only on reset or on an accepted handshake (valid&&ready).
REQ-030 datos, parity_err, frame_err SHALL remain stable while valid=1 and ready=0.
REQ-031 Frames with frame_err or parity_err SHALL still be delivered with valid; flags describe that word only.
REQ-032 Back-to-back frames (stop bit followed immediately by start edge) SHALL be received without loss.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, all counters 0, synchroniser to 1, datos 0, valid/parity_err/frame_err/overrun/busy 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh start edge.
REQ-035 Reset deassertion SHALL be sampled by clk; first start edge recognised no earlier than 2 cycles after release.

Verification (DATA_BITS=8, OVERSAMPLE=16, CLK_PER_SAMPLE=4, bit = 64 clk)
REQ-036 Frame 0xA5, PARITY=0, one stop bit, ready=1 -> valid one cycle, datos=0xA5, errors 0, busy low after stop.
REQ-037 PARITY=1, send 0x03 with parity bit 1 -> datos=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-038 Stop bit driven low for 0x5A, then rx held low 200 clk -> frame_err=1, datos=0x5A, block in BREAK until rx high, next frame 0x11 received clean.
REQ-039 Low glitch of 20 clk on idle rx -> no valid, busy returns low, state IDLE.
REQ-040 ready=0, send 0x12 then 0x34 back-to-back -> datos stays 0x12, overrun=1; pulse ready -> overrun=0, valid=0.
REQ-041 Assert rst_n low during bit 4 of a frame -> all outputs 0 immediately; after release, frame 0xC3 received correctly.
